multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction-register bits [31:26]; stable from DECODE until the next FETCH.
REQ-005 mem_ready  input  1  shared memory has completed the current access this cycle.
REQ-006 pc_write, pc_write_cond, branch_not  output  1 each  unconditional PC write; PC write gated by zero; invert zero (bne).
REQ-007 ir_write, i_or_d, mem_read, mem_write  output  1 each  IR load; memory address select (0 = pc, 1 = alu_out); memory strobes.
REQ-008 reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  register-file controls; ALU A select (0 = pc, 1 = rdA).
REQ-009 alu_src_b  output  2  ALU B select: 00 = rdB, 01 = constant 4, 10 = ext_val, 11 = ext_val*4.
REQ-010 alu_op, pc_source  output  2 each  ALU control class (00 = add, 01 = sub, 10 = funct); PC source (00 = alu, 01 = alu_out reg, 10 = jump target).
REQ-011 state  output  4  current state encoding.
REQ-012 instr_done, illegal  output  1 each  one-cycle pulse on the final state of each instruction; sticky trap flag.

Function
REQ-013 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=15.
REQ-014 Opcodes: RTYPE 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, LW 0x23, SW 0x2B.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; on mem_ready go to DECODE, otherwise hold in FETCH.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state LW/SW -> MEMADR, RTYPE -> EXEC, BEQ/BNE -> BRANCH, J -> JUMP, ADDI -> IEXEC, any other opcode -> TRAP.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state LW -> MEMRD, SW -> MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready, then go to MEMWB.
REQ-019 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; next state FETCH.
REQ-020 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready; on mem_ready assert instr_done and go to FETCH.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next state FETCH.
REQ-022 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next state IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next state FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, branch_not=(opcode==BNE), instr_done=1; next state FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10, instr_done=1; next state FETCH.
REQ-025 TRAP: illegal=1 and all strobes 0; stay in TRAP until reset.
REQ-026 Any output not listed for a state is 0 in that state; outputs are a Moore decode of state, except the mem_ready-qualified terms.
REQ-027 Cycle counts with mem_ready constantly 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3.
REQ-028 Wait states: every cycle spent waiting repeats the identical outputs; mem_write is never pulsed twice for one SW.

Reset
REQ-029 While reset is high, the next state is FETCH, illegal clears, and reset overrides every transition, including mid-wait and TRAP.
REQ-030 In the cycle after reset deasserts, state=0 and the outputs are the FETCH decode.

Structure
REQ-031 A shared package holds the state encodings, opcode constants, alu_src_b/alu_op/pc_source codes and the state width.
REQ-032 Split into next-state logic and output decode; the output decode is the natural sub-module, multi_cycle_decode, which is purely combinational from state, opcode and mem_ready.

Verification
REQ-033 Reset, then opcode=0x23 with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-034 opcode=0x2B, mem_ready low for 3 cycles in MEMWR -> mem_write held high for 4 cycles; one instr_done pulse.
REQ-035 opcode=0x05 -> BRANCH with pc_write_cond=1, branch_not=1, pc_source=01; opcode=0x04 gives branch_not=0.
REQ-036 opcode=0x3F -> DECODE goes to TRAP(15) with illegal=1 held; reset then returns state to 0 with illegal=0.
REQ-037 mem_ready=0 in FETCH for 2 cycles -> ir_write=0 and pc_write=0 until mem_ready rises; a single ir_write pulse follows.
REQ-038 Reset asserted during MEMRD -> next state 0 with no reg_write; MEM_WAIT_EN=0 ignores mem_ready=0 (LW completes in 5 cycles).

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: shared state, opcode and control-field encodings for the multi-cycle controller.
package multi_cycle_ctrl_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd15
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [1:0] SRCB_RDB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_EXT4 = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_not;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: instruction/memory status in, datapath control strobes out.
interface multi_cycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_not;
  logic       ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [multi_cycle_ctrl_pkg::STATE_W-1:0] state;
  logic       instr_done, illegal;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_not, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, illegal
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_not, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           state, instr_done, illegal
  );
endinterface

// File: rtl/multi_cycle_decode.sv
// multi_cycle_decode: Moore output decode of controller state, plus mem_ready-qualified strobes.
module multi_cycle_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_EXT4;
      S_MEMADR, S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_EXT;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RDB;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_source     = PC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.branch_not    = opcode_i == OP_BNE;
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_TRAP: ctrl_o.illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-style control FSM; state register and next-state logic, outputs via multi_cycle_decode.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic              clock,
  input logic              reset,
  multi_cycle_ctrl_if.master bus
);
  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   rdy;
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  always_ff @(posedge clock) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_IEXEC;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = bus.opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end
  multi_cycle_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (bus.opcode),
    .mem_ready_i(rdy),
    .ctrl_o     (ctrl)
  );
  assign bus.state         = state_q;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.branch_not    = ctrl.branch_not;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal       = ctrl.illegal;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench; expected state/ready per cycle queued, outputs checked against a reference decode.
module tb_multi_cycle_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int n_wr, n_done, n_ir;
  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } exp_t;
  exp_t sb_q[$];
  multi_cycle_ctrl_if bus ();
  multi_cycle_ctrl_if bus2 ();
  multi_cycle_ctrl #(.MEM_WAIT_EN(1'b1)) u_dut  (.clock(clock), .reset(reset), .bus(bus));
  multi_cycle_ctrl #(.MEM_WAIT_EN(1'b0)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [18:0] observed();
    return {bus.pc_write, bus.pc_write_cond, bus.branch_not, bus.ir_write, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal};
  endfunction
  function automatic logic [18:0] reference(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic pw = 0, pwc = 0, bn = 0, irw = 0, iod = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, dn = 0, il = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; dn = 1; end
      4'd5:  begin mw = 1; iod = 1; dn = rdy; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; bn = (op == 6'h05); dn = 1; end
      4'd9:  begin pw = 1; ps = 2'b10; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; dn = 1; end
      4'd15: il = 1;
      default: ;
    endcase
    return {pw, pwc, bn, irw, iod, mr, mw, rw, rd, m2r, sa, sb, ao, ps, dn, il};
  endfunction
  task automatic push(input logic [3:0] st, input logic rdy);
    exp_t e;
    e.st = st;
    e.rdy = rdy;
    sb_q.push_back(e);
  endtask
  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.mem_ready = e.rdy;
      @(negedge clock);
      check({tag, "_state"}, 32'(bus.state), 32'(e.st));
      check({tag, "_out"}, 32'(observed()), 32'(reference(e.st, bus.opcode, e.rdy)));
      n_wr += int'(bus.mem_write);
      n_done += int'(bus.instr_done);
      n_ir += int'(bus.ir_write);
      @(posedge clock);
      #1;
    end
    bus.mem_ready = 1'b1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    logic [3:0] seq[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;
    bus2.opcode = 6'h00;
    bus2.mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    bus.opcode = 6'h23;
    for (int i = 0; i < 5; i++) push(4'(i), 1'b1);
    drain("lw");
    n_wr = 0; n_done = 0;
    bus.opcode = 6'h2B;
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 1);
    push(4'd5, 0); push(4'd5, 0); push(4'd5, 0); push(4'd5, 1);
    drain("sw");
    check("sw_mem_write_cycles", 32'(n_wr), 32'd4);
    check("sw_instr_done", 32'(n_done), 32'd1);
    bus.opcode = 6'h05;
    push(4'd0, 1); push(4'd1, 1); push(4'd8, 1);
    drain("bne");
    bus.opcode = 6'h04;
    push(4'd0, 1); push(4'd1, 1); push(4'd8, 1);
    drain("beq");
    n_ir = 0;
    bus.opcode = 6'h00;
    push(4'd0, 0); push(4'd0, 0); push(4'd0, 1); push(4'd1, 1); push(4'd6, 1); push(4'd7, 1);
    drain("rtype_fetch_wait");
    check("fetch_ir_pulses", 32'(n_ir), 32'd1);
    bus.opcode = 6'h08;
    push(4'd0, 1); push(4'd1, 1); push(4'd10, 1); push(4'd11, 1);
    drain("addi");
    bus.opcode = 6'h02;
    push(4'd0, 1); push(4'd1, 1); push(4'd9, 1);
    drain("j");
    bus.opcode = 6'h23;
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 1); push(4'd3, 0);
    drain("lw_pre_reset");
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rst_memrd_state", 32'(bus.state), 32'd3);
    check("rst_memrd_reg_write", 32'(bus.reg_write), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_after_state", 32'(bus.state), 32'd0);
    check("rst_after_reg_write", 32'(bus.reg_write), 32'd0);
    @(posedge clock);
    #1;
    bus.opcode = 6'h3F;
    push(4'd0, 1); push(4'd1, 1); push(4'd15, 1); push(4'd15, 0); push(4'd15, 1);
    drain("trap");
    pulse_reset();
    @(negedge clock);
    check("trap_reset_state", 32'(bus.state), 32'd0);
    check("trap_reset_illegal", 32'(bus.illegal), 32'd0);
    bus2.opcode = 6'h23;
    bus2.mem_ready = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("lw_nowait_state", 32'(bus2.state), 32'(seq[i]));
      @(posedge clock);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
